rx_axis_drop_fifo: RTL

- Store-and-forward packet FIFO directly downstream of the 10G MAC receive AXI-Stream port (rx_axis_*); MAC RX output has no backpressure.
- Buffers each frame, commits it only if it ends with tlast and tuser=0; frames flagged bad by the MAC or overflowing the buffer are discarded whole.
- Presents only good, complete frames on a standard AXI-Stream master with tready for the user/application logic.

---
 rtl/rx_axis_drop_fifo_if.sv | 12 +
 rtl/rx_axis_drop_fifo.sv | 136 +++++++++++++
 2 files changed

// File: rtl/rx_axis_drop_fifo_if.sv
// AXI-Stream bundle shared by the MAC-side input and the application-side output.
interface rx_axis_drop_fifo_if #(parameter int DATA_W = 64);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tlast;
  logic                tuser;
  logic                tready;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/rx_axis_drop_fifo.sv
// Store-and-forward RX frame FIFO: frames are committed only when they end good; bad or
// overflowing frames are rewound away. Optional counters under RX_DROP_FIFO_STATS_EN.
module rx_axis_drop_fifo #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 64
) (
  input  logic                  clk_i,
  input  logic                  aresetn_i,
  rx_axis_drop_fifo_if.slave    s_axis,
  rx_axis_drop_fifo_if.master   m_axis,
  output logic                  frame_avail_o
`ifdef RX_DROP_FIFO_STATS_EN
  ,
  output logic [31:0]           good_cnt_o,
  output logic [31:0]           bad_cnt_o,
  output logic [31:0]           ovf_cnt_o
`endif
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int WORD_W = DATA_W + KEEP_W + 1;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [1:0] SYNC  = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] FRAME = 2'd2;
  localparam logic [1:0] DROP  = 2'd3;

  localparam logic [ADDR_W:0] FULL_DIFF = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]        state;
  logic [ADDR_W:0]   wr_spec, wr_commit, rd;
  logic [WORD_W-1:0] mem [DEPTH];
  logic              full, in_frame, wr_en;

  logic              m_vld, m_last;
  logic [KEEP_W-1:0] m_keep;
  logic [DATA_W-1:0] m_data;
  logic              pop, load;

  // The MAC cannot be stalled; every valid word is consumed.
  assign s_axis.tready = 1'b1;

  assign full     = (wr_spec - rd) == FULL_DIFF;
  assign in_frame = (state == IDLE) || (state == FRAME);
  assign wr_en    = s_axis.tvalid && in_frame && !full;

  always_ff @(posedge clk_i)
    if (wr_en) mem[wr_spec[ADDR_W-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};

  // wr_spec runs ahead over the frame in progress; wr_commit only moves on a good tlast.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state     <= SYNC;
      wr_spec   <= '0;
      wr_commit <= '0;
    end else begin
      case (state)
        SYNC: if (s_axis.tvalid && s_axis.tlast) state <= IDLE;
        IDLE, FRAME: if (s_axis.tvalid) begin
          if (full) begin
            if (s_axis.tlast) begin
              wr_spec <= wr_commit;
              state   <= IDLE;
            end else begin
              state   <= DROP;
            end
          end else if (s_axis.tlast) begin
            if (s_axis.tuser) begin
              wr_spec <= wr_commit;
            end else begin
              wr_spec   <= wr_spec + 1'b1;
              wr_commit <= wr_spec + 1'b1;
            end
            state <= IDLE;
          end else begin
            wr_spec <= wr_spec + 1'b1;
            state   <= FRAME;
          end
        end
        DROP: if (s_axis.tvalid && s_axis.tlast) begin
          wr_spec <= wr_commit;
          state   <= IDLE;
        end
        default: state <= SYNC;
      endcase
    end
  end

  // Output register is fed straight from the asynchronous-read array, so a committed
  // word reaches m_axis one cycle after commit and refills on every accepted beat.
  assign pop  = m_vld && m_axis.tready;
  assign load = (rd != wr_commit) && (!m_vld || pop);

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      rd     <= '0;
      m_vld  <= 1'b0;
      m_last <= 1'b0;
      m_keep <= '0;
      m_data <= '0;
    end else if (load) begin
      {m_last, m_keep, m_data} <= mem[rd[ADDR_W-1:0]];
      m_vld <= 1'b1;
      rd    <= rd + 1'b1;
    end else if (pop) begin
      m_vld <= 1'b0;
    end
  end

  assign m_axis.tvalid = m_vld;
  assign m_axis.tlast  = m_last;
  assign m_axis.tkeep  = m_keep;
  assign m_axis.tdata  = m_data;
  assign m_axis.tuser  = 1'b0;
  assign frame_avail_o = (wr_commit != rd) || m_vld;

`ifdef RX_DROP_FIFO_STATS_EN
  logic eof, good_ev, bad_ev, ovf_ev;
  assign eof     = s_axis.tvalid && s_axis.tlast;
  assign good_ev = eof && in_frame && !full && !s_axis.tuser;
  assign bad_ev  = eof && in_frame && !full &&  s_axis.tuser;
  assign ovf_ev  = eof && ((in_frame && full) || (state == DROP));

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      good_cnt_o <= '0;
      bad_cnt_o  <= '0;
      ovf_cnt_o  <= '0;
    end else begin
      if (good_ev && good_cnt_o != 32'hFFFF_FFFF) good_cnt_o <= good_cnt_o + 1'b1;
      if (bad_ev  && bad_cnt_o  != 32'hFFFF_FFFF) bad_cnt_o  <= bad_cnt_o  + 1'b1;
      if (ovf_ev  && ovf_cnt_o  != 32'hFFFF_FFFF) ovf_cnt_o  <= ovf_cnt_o  + 1'b1;
    end
  end
`endif
endmodule
